deserializador_8bit: RTL and testbench
======================================

# deserializador_8bit

Serial-in/parallel-out receiver: collects bits from a one-bit data line, one bit per qualified write strobe, MSB first. Once a full word is assembled it presents it on a parallel output and raises a ready flag. The flag stays high until the consumer acknowledges. The block sits between a bit-serial producer and a byte-wide consumer, providing single-word buffering with a ready/ack handshake.

## Interface
- `DATA_WIDTH`, default 8: word width in bits (≥2); the counter width is $clog2(DATA_WIDTH+1).
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset; release is synchronous to `clock` by the surrounding design.
- `data_in` input 1: serial data bit, sampled only when `write_in`=1.
- `write_in` input 1: bit strobe; each rising edge with `write_in`=1 and `status_out`=1 accepts one bit.
- `ack_in` input 1: consumer acknowledge; clears `data_ready`.
- `data_out` output DATA_WIDTH: last completed word, registered.
- `data_ready` output 1: a completed, unacknowledged word is on `data_out`.
- `status_out` output 1: 1 = accepting bits; combinational, equals ~`data_ready`.
- `overrun_out` output 1: present only with `DESERIALIZADOR_OVERRUN_EN` (see Configuration).

## Operation
- Two states:
  - COLLECT: `data_ready`=0.
  - FULL: `data_ready`=1.
- COLLECT, accepted write:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_in}; count++.
  - First bit received ends up as `data_out[DATA_WIDTH-1]` (MSB first).
- On the DATA_WIDTH-th accepted bit:
  - `data_out` <= the complete word, including the bit accepted that cycle.
  - `data_ready` <= 1, count <= 0, state -> FULL.
- `data_out` does not change while partial words are collected; it holds the previous word.
- FULL:
  - `write_in` is ignored; no shift, no count change.
  - `ack_in`=1 -> `data_ready` <= 0, state -> COLLECT. `data_out` keeps its value.
- `ack_in` in COLLECT has no effect.
- Same cycle `ack_in`=1 and `write_in`=1 in FULL: the ack is taken and the write is dropped, because `status_out` was 0 at that edge.
- No timeout: a partial word persists indefinitely between strobes.
- Reset (asynchronous, mid-word or in FULL):
  - `data_out`=0, `data_ready`=0, `status_out`=1, shift_reg=0, count=0.
  - Partial bits are discarded.

## Timing
- One bit per clock maximum; `write_in` may stay high on consecutive cycles, and each such cycle accepts one bit.
- Latency: `data_ready` and the new `data_out` are visible right after the edge that accepts the last bit.
- `data_ready` deasserts right after the first edge with `ack_in`=1.
- New bits are accepted from the following edge onward.
- Minimum word period: DATA_WIDTH+1 cycles, including the ack cycle.
- `status_out` follows `data_ready` combinationally, with no extra cycle.

## Configuration
- `DESERIALIZADOR_OVERRUN_EN` defined:
  - Adds output `overrun_out`, reset value 0.
  - Set on any edge where `write_in`=1 and `data_ready`=1 (bit lost).
  - Cleared together with `data_ready` by `ack_in`.
  - Sticky until then.
- Not defined: the port and its logic are absent; lost bits are silently ignored.

## Test plan
- Reset, then 8 strobes (1 cycle high, 1 low) carrying 1,0,1,1,0,1,1,0 -> `data_ready`=1, `data_out`=8'hB6, `status_out`=0; pulse `ack_in` -> `data_ready`=0, `status_out`=1, `data_out` still 8'hB6.
- Back-to-back `write_in` for 8 cycles with 8'hA5 -> `data_ready` high after the 8th edge; after ack, send 8'h3C -> `data_out`=8'h3C.
- In FULL with 8'hB6 held, pulse `write_in` with data_in=0 three times, then ack and send 8'h01 -> `data_out`=8'h01 (extra bits ignored); with the macro, `overrun_out`=1 until the ack.
- Assert `reset` low after 4 of 8 bits of 8'hFF, release, send 8'h0F -> `data_out`=8'h0F; with `reset` asserted, all outputs are at reset values.
- `ack_in` and `write_in` together in FULL -> ack honoured, bit dropped; the next 8 bits form the next word.
- `ack_in` pulsed in COLLECT after 3 bits -> no effect; the word completes after 5 more bits.

Source files
------------

// File: rtl/deserializador_8bit.sv
// Serial-in/parallel-out receiver, MSB first, with single-word buffering and ready/ack handshake.
// Optional sticky overrun flag enabled by defining DESERIALIZADOR_OVERRUN_EN.
module deserializador_8bit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  ack_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_ready,
    output logic                  status_out
`ifdef DESERIALIZADOR_OVERRUN_EN
    ,
    output logic                  overrun_out
`endif
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CW-1:0]         count, count_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= COLLECT;
            shift_reg <= '0;
            count     <= '0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            count     <= count_next;
            data_out  <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        count_next = count;
        data_next  = data_out;
        case (state)
            COLLECT: begin
                if (write_in) begin
                    shift_next = {shift_reg[DATA_WIDTH-2:0], data_in};
                    // The completing bit goes straight into data_out in the same cycle.
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        data_next  = shift_next;
                        count_next = '0;
                        state_next = FULL;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            FULL: begin
                if (ack_in) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign data_ready = (state == FULL);
    assign status_out = ~data_ready;

`ifdef DESERIALIZADOR_OVERRUN_EN
    // Ack wins over a simultaneous dropped bit: the word it protected is being consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_out <= 1'b0;
        end else if (data_ready && ack_in) begin
            overrun_out <= 1'b0;
        end else if (data_ready && write_in) begin
            overrun_out <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deserializador_8bit.sv
// Directed bench for deserializador_8bit: handshake, back-to-back bits, ignored writes,
// async reset mid-word, ack/write collision and ack during collection.
module tb_deserializador_8bit;

    logic       clock;
    logic       reset;
    logic       data_in;
    logic       write_in;
    logic       ack_in;
    logic [7:0] data_out;
    logic       data_ready;
    logic       status_out;
`ifdef DESERIALIZADOR_OVERRUN_EN
    logic       overrun_out;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    deserializador_8bit #(.DATA_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (ack_in),
        .data_out   (data_out),
        .data_ready (data_ready),
        .status_out (status_out)
`ifdef DESERIALIZADOR_OVERRUN_EN
        ,
        .overrun_out(overrun_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at negedge, capture at posedge, return 1 time unit later with inputs idle.
    task automatic step(input logic w, input logic d, input logic a);
        @(negedge clock);
        write_in = w;
        data_in  = d;
        ack_in   = a;
        @(posedge clock);
        #1;
        write_in = 1'b0;
        data_in  = 1'b0;
        ack_in   = 1'b0;
    endtask

    // Sends bits word[7-from] down to word[7-from-num+1], optionally with an idle cycle after each.
    task automatic send_bits(input logic [7:0] word, input int unsigned from,
                             input int unsigned num, input bit gap);
        for (int unsigned i = 0; i < num; i++) begin
            step(1'b1, word[7-from-i], 1'b0);
            if (gap) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        data_in  = 1'b0;
        write_in = 1'b0;
        ack_in   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_status", 32'(status_out), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Strobed word B6
        send_bits(8'hB6, 0, 7, 1'b1);
        check("b6_partial_ready", 32'(data_ready), 32'd0);
        check("b6_partial_data", 32'(data_out), 32'h00);
        send_bits(8'hB6, 7, 1, 1'b1);
        check("b6_ready", 32'(data_ready), 32'd1);
        check("b6_data", 32'(data_out), 32'hB6);
        check("b6_status", 32'(status_out), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("b6_ack_ready", 32'(data_ready), 32'd0);
        check("b6_ack_status", 32'(status_out), 32'd1);
        check("b6_ack_data", 32'(data_out), 32'hB6);

        // Back-to-back A5 then 3C
        send_bits(8'hA5, 0, 7, 1'b0);
        check("a5_partial_ready", 32'(data_ready), 32'd0);
        send_bits(8'hA5, 7, 1, 1'b0);
        check("a5_ready", 32'(data_ready), 32'd1);
        check("a5_data", 32'(data_out), 32'hA5);
        step(1'b0, 1'b0, 1'b1);
        send_bits(8'h3C, 0, 8, 1'b0);
        check("3c_ready", 32'(data_ready), 32'd1);
        check("3c_data", 32'(data_out), 32'h3C);
        step(1'b0, 1'b0, 1'b1);

        // Writes while FULL are ignored
        send_bits(8'hB6, 0, 8, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("full_wr_ready", 32'(data_ready), 32'd1);
        check("full_wr_data", 32'(data_out), 32'hB6);
`ifdef DESERIALIZADOR_OVERRUN_EN
        check("overrun_set", 32'(overrun_out), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b1);
        check("full_wr_ack_ready", 32'(data_ready), 32'd0);
`ifdef DESERIALIZADOR_OVERRUN_EN
        check("overrun_clr", 32'(overrun_out), 32'd0);
`endif
        send_bits(8'h01, 0, 8, 1'b0);
        check("01_data", 32'(data_out), 32'h01);
        check("01_ready", 32'(data_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 4 bits of FF
        send_bits(8'hFF, 0, 4, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'h00);
        check("midrst_ready", 32'(data_ready), 32'd0);
        check("midrst_status", 32'(status_out), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        send_bits(8'h0F, 0, 7, 1'b0);
        check("0f_partial_ready", 32'(data_ready), 32'd0);
        send_bits(8'h0F, 7, 1, 1'b0);
        check("0f_data", 32'(data_out), 32'h0F);
        check("0f_ready", 32'(data_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        // Ack and write on the same FULL edge: bit dropped
        send_bits(8'h55, 0, 8, 1'b0);
        check("55_data", 32'(data_out), 32'h55);
        step(1'b1, 1'b1, 1'b1);
        check("collide_ready", 32'(data_ready), 32'd0);
        check("collide_status", 32'(status_out), 32'd1);
        send_bits(8'hC3, 0, 7, 1'b0);
        check("c3_partial_ready", 32'(data_ready), 32'd0);
        send_bits(8'hC3, 7, 1, 1'b0);
        check("c3_data", 32'(data_out), 32'hC3);
        check("c3_ready", 32'(data_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        // Ack during COLLECT has no effect
        send_bits(8'h9A, 0, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("collect_ack_ready", 32'(data_ready), 32'd0);
        check("collect_ack_data", 32'(data_out), 32'hC3);
        send_bits(8'h9A, 3, 4, 1'b0);
        check("9a_partial_ready", 32'(data_ready), 32'd0);
        send_bits(8'h9A, 7, 1, 1'b0);
        check("9a_data", 32'(data_out), 32'h9A);
        check("9a_ready", 32'(data_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
